// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic initiator.
// Accepts one command on a valid/ready port, runs exactly one Wishbone read or
// write cycle, and returns read data plus an error flag on a valid/ready
// response port. A bus timeout aborts cycles that a slave never acknowledges.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_we, cmd_adr, cmd_sel,     command: direction, byte address, lane
//   cmd_dat                       select, write data
//   rsp_valid/rsp_ready           response handshake
//   rsp_dat, rsp_err              read data (0 for writes/errors), timeout flag
//   wb_cyc_o .. wb_dat_o          Wishbone initiator outputs (all registered)
//   wb_dat_i, wb_ack_i            Wishbone read data and acknowledge
//   busy                          high whenever a command is in progress
module wb_master_bridge #(
  parameter int unsigned addr_width     = 32,
  parameter int unsigned timeout_cycles = 255,
  parameter int unsigned cnt_width      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [addr_width-1:0] cmd_adr,
  input  logic [3:0]            cmd_sel,
  input  logic [31:0]           cmd_dat,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_dat,
  output logic                  rsp_err,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [addr_width-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  localparam bit TimeoutEn = (timeout_cycles != 0);
  // Counter value on the last permitted BUS edge; cyc/stb then span exactly
  // timeout_cycles cycles because the counter is cleared on the accept edge.
  localparam logic [cnt_width-1:0] CntLast =
    TimeoutEn ? cnt_width'(timeout_cycles - 1) : '0;

  state_e               state_q;
  logic [cnt_width-1:0] cnt_q;

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_sel_o  <= '0;
      wb_dat_o  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= cmd_we;
            wb_adr_o <= cmd_adr;
            wb_sel_o <= cmd_sel;
            wb_dat_o <= cmd_dat;
            cnt_q    <= '0;
            state_q  <= StBus;
          end
        end
        StBus: begin
          // Ack has priority over a timeout landing on the same edge.
          if (wb_ack_i) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            rsp_dat   <= wb_we_o ? 32'h0 : wb_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else if (TimeoutEn && (cnt_q == CntLast)) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            rsp_dat   <= 32'h0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Single-outstanding Wishbone classic initiator; the bus-master end of the Wishbone slave register blocks (MMU, peripherals).
- Turns a valid/ready command port into one Wishbone read or write cycle, then returns read data and error on a valid/ready response port.
- Bus timeout guards against non-acking slaves.
- Used by the debug/boot loader path to program slave registers.

Parameters:
addr_width, 32, width of cmd_adr and wb_adr_o
timeout_cycles, 255, cycles with cyc/stb asserted before abort; 0 disables timeout
cnt_width, 8, timeout counter width; must hold timeout_cycles

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  bridge can accept a command
cmd_we  in  1  1 = write, 0 = read
cmd_adr  in  addr_width  byte address
cmd_sel  in  4  byte lane select
cmd_dat  in  32  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_dat  out  32  read data; 0 for writes and errors
rsp_err  out  1  1 = transaction timed out
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  addr_width  Wishbone address
wb_sel_o  out  4  Wishbone byte select
wb_dat_o  out  32  Wishbone write data
wb_dat_i  in  32  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any time): state IDLE; wb_cyc_o = wb_stb_o = wb_we_o = 0; wb_adr_o, wb_sel_o, wb_dat_o, rsp_dat = 0; rsp_valid = rsp_err = 0; counter = 0. An in-flight bus cycle or pending response is dropped and not replayed.
- All outputs are registered. cmd_ready = (state == IDLE) and is combinational from state only.
- IDLE: on cmd_valid & cmd_ready at edge N:
  - latch we/adr/sel/dat onto the wb_*_o outputs;
  - assert wb_cyc_o and wb_stb_o after edge N;
  - clear the counter; go to BUS.
- BUS:
  - wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o and wb_dat_o stay constant.
  - At an edge with wb_ack_i = 1:
    - drop cyc/stb/we;
    - rsp_dat = wb_dat_i for a read, 0 for a write;
    - rsp_err = 0; rsp_valid = 1; go to RESP.
  - Only one ack is consumed per command. Ack is sampled, never used combinationally.
  - Otherwise, if timeout_cycles != 0 and counter == timeout_cycles-1:
    - drop cyc/stb/we;
    - rsp_err = 1; rsp_dat = 0; rsp_valid = 1; go to RESP.
    - cyc/stb are therefore high for exactly timeout_cycles cycles.
  - Otherwise increment the counter (saturating at all-ones).
  - Ack on the same edge as the timeout: ack wins, rsp_err = 0.
- RESP: rsp_valid, rsp_dat and rsp_err stay stable until rsp_ready = 1 at an edge. Then rsp_valid = 0 and state returns to IDLE.
- Throughput:
  - cmd_ready is low in BUS and RESP, so back-to-back commands take at least 3 cycles each (accept, bus, response) with a zero-wait slave.
  - Against a slave with a registered ack (ack one cycle after stb seen), the minimum is 4 cycles.
- wb_ack_i outside BUS is ignored. A spurious ack must not create a response.
- wb_adr_o, wb_sel_o and wb_dat_o hold their last values in IDLE/RESP. wb_cyc_o == wb_stb_o at all times.

Test Plan:
1. Write, registered-ack slave. cmd_we=1, adr=0x04, dat=0x1000, sel=0xF accepted at edge N:
   - cyc/stb high after N; slave ack seen at edge N+2;
   - cyc/stb low after N+2; rsp_valid=1, rsp_err=0, rsp_dat=0;
   - slave register 0x04 reads back 0x1000.
2. Read. cmd_we=0, adr=0x08, slave returns 0x00000020 → rsp_dat=0x20, rsp_err=0; wb_we_o=0 throughout BUS.
3. Timeout, timeout_cycles=4, wb_ack_i tied 0:
   - cyc/stb high for exactly 4 cycles;
   - then rsp_valid=1, rsp_err=1, rsp_dat=0;
   - cmd_ready stays low until rsp_ready.
4. Backpressure:
   - hold rsp_ready=0 for 10 cycles after a read; rsp_valid/rsp_dat stay stable and cmd_ready stays 0;
   - raising rsp_ready gives IDLE next cycle;
   - a second queued cmd_valid is accepted only then.
5. Async reset asserted mid-BUS (between clock edges) → wb_cyc_o/wb_stb_o/rsp_valid go 0 immediately; busy=0 and cmd_ready=1 after release; a later ack is ignored.
6. Ack on the timeout edge (timeout_cycles=3, ack at 3rd BUS edge) → rsp_err=0, rsp_dat=wb_dat_i. A spurious ack in IDLE → no rsp_valid.
